// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer.
//   state_e     : sequencer state encoding (IDLE/RUN/DRAIN/DONE)
//   BE_ALL_ONES : all-ones byteenable, truncated to the bus width by users
package capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned BE_MAX_WIDTH = 64;
   localparam logic [BE_MAX_WIDTH-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
//   clk, reset_n : clock, async active-low reset
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dout         : head entry, valid while !empty
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module sync_fifo #(
   parameter int unsigned WIDTH      = 27,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned CW = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is not reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: gates DUT stimulus with sample_enable, buffers samples
// in a FIFO and writes each one to memory as a single Avalon-MM word.
//   clk, reset_n          : clock, async active-low reset
//   start, auto_rearm     : arm a run / re-arm automatically after done
//   fixed_location        : all words go to the latched base address
//   base_address          : first word address, latched at arm
//   sample_count          : samples per run, latched at arm
//   sample_data           : DUT output, captured on edges with sample_enable=1
//   sample_enable         : clock-enable for LFSRs/DUT
//   avm_*                 : Avalon-MM write master
//   busy, done            : run in progress / one-cycle completion pulse
//   words_written         : words accepted in the current or last run
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH    = 27,
   parameter int unsigned DATAWIDTH       = 32,
   parameter int unsigned BYTEENABLEWIDTH = 4,
   parameter int unsigned ADDRESSWIDTH    = 32,
   parameter int unsigned FIFODEPTH       = 16,
   parameter int unsigned FIFODEPTH_LOG2  = 4,
   parameter int unsigned COUNT_WIDTH     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       auto_rearm,
   input  logic                       fixed_location,
   input  logic [ADDRESSWIDTH-1:0]    base_address,
   input  logic [COUNT_WIDTH-1:0]     sample_count,
   input  logic [SAMPLE_WIDTH-1:0]    sample_data,
   output logic                       sample_enable,
   output logic [ADDRESSWIDTH-1:0]    avm_address,
   output logic                       avm_write,
   output logic [BYTEENABLEWIDTH-1:0] avm_byteenable,
   output logic [DATAWIDTH-1:0]       avm_writedata,
   input  logic                       avm_waitrequest,
   output logic                       busy,
   output logic                       done,
   output logic [COUNT_WIDTH-1:0]     words_written
);

   localparam int unsigned FCW = FIFODEPTH_LOG2 + 1;

   state_e                   state_q, state_d;
   logic [COUNT_WIDTH-1:0]   count_q, count_d;
   logic [COUNT_WIDTH-1:0]   issued_q, issued_d;
   logic [COUNT_WIDTH-1:0]   words_q, words_d;
   logic [ADDRESSWIDTH-1:0]  addr_q, addr_d;
   logic [DATAWIDTH-1:0]     wdata_q, wdata_d;
   logic                     write_q, write_d;
   logic                     en_q, en_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                     push, pop, accept, arm;
   logic [SAMPLE_WIDTH-1:0]  fifo_dout;
   logic [FCW-1:0]           fifo_count, fifo_count_nxt;
   logic                     fifo_full, fifo_empty;

   // Sample buffer between the DUT and the write master.
   sync_fifo #(
      .WIDTH      (SAMPLE_WIDTH),
      .DEPTH      (FIFODEPTH),
      .DEPTH_LOG2 (FIFODEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (sample_data),
      .pop     (pop),
      .dout    (fifo_dout),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign push   = en_q && !fifo_full;
   assign accept = write_q && !avm_waitrequest;
   // Refill the write register when idle or in the same edge it drains.
   assign pop    = !fifo_empty && (!write_q || accept);
   assign fifo_count_nxt = fifo_count + FCW'(push) - FCW'(pop);

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      issued_d = issued_q;
      words_d  = words_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      arm      = 1'b0;

      // Write side runs independently of the sequencer state.
      if (pop) begin
         write_d = 1'b1;
         wdata_d = DATAWIDTH'(fifo_dout);
      end else if (accept) begin
         write_d = 1'b0;
      end
      if (accept) begin
         words_d = words_q + COUNT_WIDTH'(1);
         if (!fixed_location) addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
      end
      if (push) issued_d = issued_q + COUNT_WIDTH'(1);

      case (state_q)
         ST_IDLE:  if (start) arm = 1'b1;
         ST_RUN:   if (issued_d == count_q) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_count_nxt == '0 && !write_d) state_d = ST_DONE;
         ST_DONE:  if (auto_rearm) arm = 1'b1; else state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (arm) begin
         count_d  = sample_count;
         issued_d = '0;
         words_d  = '0;
         addr_d   = base_address;
         state_d  = (sample_count == '0) ? ST_DONE : ST_RUN;
      end

      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      // Enable only if the next edge's push still fits after this edge settles.
      en_d   = (state_d == ST_RUN) && (issued_d < count_d) &&
               (fifo_count_nxt < FCW'(FIFODEPTH));
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         issued_q <= '0;
         words_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         words_q  <= words_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sample_enable  = en_q;
   assign avm_address    = addr_q;
   assign avm_write      = write_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = BYTEENABLEWIDTH'(BE_ALL_ONES);
   assign busy           = busy_q;
   assign done           = done_q;
   assign words_written  = words_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer (FIFODEPTH=4 instance).
`timescale 1ns/1ps
module tb_capture_sequencer;

   localparam int unsigned SW  = 27;
   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned FD  = 4;
   localparam int unsigned FDL = 2;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          auto_rearm = 1'b0;
   logic          fixed_location = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic [CW-1:0] sample_count = '0;
   logic [SW-1:0] sample_data = SW'(1);
   logic          avm_waitrequest = 1'b0;
   logic          sample_enable;
   logic [AW-1:0] avm_address;
   logic          avm_write;
   logic [BEW-1:0] avm_byteenable;
   logic [DW-1:0] avm_writedata;
   logic          busy;
   logic          done;
   logic [CW-1:0] words_written;

   always #5 clk = ~clk;

   capture_sequencer #(
      .SAMPLE_WIDTH(SW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW),
      .ADDRESSWIDTH(AW), .FIFODEPTH(FD), .FIFODEPTH_LOG2(FDL), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .auto_rearm(auto_rearm),
      .fixed_location(fixed_location), .base_address(base_address),
      .sample_count(sample_count), .sample_data(sample_data),
      .sample_enable(sample_enable), .avm_address(avm_address),
      .avm_write(avm_write), .avm_byteenable(avm_byteenable),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .words_written(words_written)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t    sb_q[$];
   exp_t    sb_e;
   int      tests = 0;
   int      fails = 0;
   int      cyc = 0;
   int      acc_cnt = 0;
   int      push_cnt = 0;
   int      last_acc_edge = 0;
   bit      seen_write = 0;
   bit      seen_en = 0;
   bit      consumed = 0;
   bit      stall_prev = 0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   // Reference model of where each pushed sample should land.
   logic [AW-1:0] m_base = '0;
   int      m_len = 1;
   bit      m_fixed = 0;
   int      m_idx = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor, scoreboard and sample-data source, all evaluated mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (avm_write && !avm_waitrequest) begin
            acc_cnt++;
            last_acc_edge = cyc + 1;
            check("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
            if (sb_q.size() > 0) begin
               sb_e = sb_q.pop_front();
               check("wr_data", 64'(avm_writedata), 64'(sb_e.data));
               check("wr_addr", 64'(avm_address), 64'(sb_e.addr));
            end
         end
         if (stall_prev) begin
            check("stall_write", 64'(avm_write), 64'(1));
            check("stall_addr", 64'(avm_address), 64'(prev_addr));
            check("stall_data", 64'(avm_writedata), 64'(prev_data));
         end
         if (avm_write) seen_write = 1;
         if (sample_enable) seen_en = 1;
         if (consumed) sample_data = sample_data + SW'(1);
         consumed = sample_enable;
         if (sample_enable) begin
            push_cnt++;
            sb_e.data = DW'(sample_data);
            sb_e.addr = m_fixed ? m_base : m_base + AW'(BEW * m_idx);
            sb_q.push_back(sb_e);
            m_idx = (m_idx + 1 == m_len) ? 0 : m_idx + 1;
         end
      end else begin
         consumed = 0;
      end
      stall_prev = reset_n && avm_write && avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_model(input logic [AW-1:0] base, input int len, input bit fixed);
      m_base = base;
      m_len = (len == 0) ? 1 : len;
      m_fixed = fixed;
      m_idx = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < budget);
      check(tag, 64'(done), 64'(1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"}, 64'(sample_enable), 64'(0));
      check({tag, "_write"}, 64'(avm_write), 64'(0));
      check({tag, "_addr"}, 64'(avm_address), 64'(0));
      check({tag, "_data"}, 64'(avm_writedata), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_words"}, 64'(words_written), 64'(0));
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      check_all_zero("reset");
      check("reset_be", 64'(avm_byteenable), 64'hF);
      reset_n = 1'b1;
      step();

      // Basic run: 5 words to 0x1000 upward
      base_address = 32'h1000; sample_count = 16'd5; fixed_location = 0;
      arm_model(32'h1000, 5, 0); acc_cnt = 0;
      pulse_start();
      check("basic_busy", 64'(busy), 64'(1));
      wait_done(100, "basic_done_timeout");
      check("basic_done_lat", 64'(cyc), 64'(last_acc_edge));
      check("basic_busy_at_done", 64'(busy), 64'(0));
      check("basic_words", 64'(words_written), 64'(5));
      check("basic_acc", 64'(acc_cnt), 64'(5));
      check("basic_sb_empty", 64'(sb_q.size()), 64'(0));
      @(negedge clk);
      check("basic_done_one_cycle", 64'(done), 64'(0));
      step();

      // Backpressure: stall 30 cycles, FIFO and write register fill up
      base_address = 32'h2000; sample_count = 16'd20; avm_waitrequest = 1;
      arm_model(32'h2000, 20, 0); push_cnt = 0;
      pulse_start();
      repeat (30) step();
      // FD entries in the FIFO plus the one word held on the bus
      check("bp_pushes", 64'(push_cnt), 64'(FD + 1));
      check("bp_en_low", 64'(sample_enable), 64'(0));
      avm_waitrequest = 0;
      wait_done(200, "bp_done_timeout");
      check("bp_words", 64'(words_written), 64'(20));
      check("bp_sb_empty", 64'(sb_q.size()), 64'(0));
      step();

      // Fixed location
      base_address = 32'h3000; sample_count = 16'd3; fixed_location = 1;
      arm_model(32'h3000, 3, 1);
      pulse_start();
      wait_done(100, "fixed_done_timeout");
      check("fixed_final_addr", 64'(avm_address), 64'h3000);
      check("fixed_words", 64'(words_written), 64'(3));
      step();
      fixed_location = 0;

      // Zero count
      seen_write = 0; seen_en = 0;
      base_address = 32'h3800; sample_count = 16'd0;
      pulse_start();
      wait_done(5, "zero_done_timeout");
      check("zero_words", 64'(words_written), 64'(0));
      repeat (3) step();
      check("zero_no_write", 64'(seen_write), 64'(0));
      check("zero_no_en", 64'(seen_en), 64'(0));

      // Auto re-arm, two runs, start pulses mid-run ignored
      base_address = 32'h4000; sample_count = 16'd4; auto_rearm = 1;
      arm_model(32'h4000, 4, 0); acc_cnt = 0;
      pulse_start();
      step();
      pulse_start();
      wait_done(100, "rearm1_done_timeout");
      check("rearm1_words", 64'(words_written), 64'(4));
      step();
      auto_rearm = 0;
      check("rearm2_busy", 64'(busy), 64'(1));
      pulse_start();
      wait_done(100, "rearm2_done_timeout");
      check("rearm2_words", 64'(words_written), 64'(4));
      check("rearm_acc", 64'(acc_cnt), 64'(8));
      repeat (3) step();
      check("rearm_idle_busy", 64'(busy), 64'(0));
      check("rearm_sb_empty", 64'(sb_q.size()), 64'(0));

      // Async reset mid-run with an outstanding stalled write
      base_address = 32'h5000; sample_count = 16'd10; avm_waitrequest = 1;
      arm_model(32'h5000, 10, 0);
      pulse_start();
      repeat (8) step();
      check("pre_reset_write", 64'(avm_write), 64'(1));
      reset_n = 0;
      #1;
      check_all_zero("abort");
      sb_q.delete();
      step();
      reset_n = 1; avm_waitrequest = 0;
      step();
      base_address = 32'h6000; sample_count = 16'd2;
      arm_model(32'h6000, 2, 0); acc_cnt = 0;
      pulse_start();
      wait_done(100, "post_reset_done_timeout");
      check("post_reset_words", 64'(words_written), 64'(2));
      check("post_reset_acc", 64'(acc_cnt), 64'(2));
      check("post_reset_sb_empty", 64'(sb_q.size()), 64'(0));
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
